// File: rtl/cu_seq_pkg.sv
// rtl/cu_seq_pkg.sv - state encoding, select encodings and output bundle for the multicycle sequencer
package cu_seq_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWR  = 4'd4,
      MEMWB  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] SRCA_RN    = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCA_PC4   = 2'b10;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_4     = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       reg_write;
      logic       mem_write;
      logic       alu_op;
   } seq_out_t;

endpackage

// File: rtl/seq_out_dec.sv
// rtl/seq_out_dec.sv - per-state datapath control decode with commit gating on cond_q
module seq_out_dec
   import cu_seq_pkg::*;
(
   input  state_t     state,
   input  logic       cond_q,
   input  logic [3:0] rd,
   input  logic       mem_ready,
   output seq_out_t   outs
);

   logic rd_pc;
   assign rd_pc = (rd == 4'd15);

   always_comb begin
      outs = '0;
      case (state)
         FETCH: begin
            outs.alu_src_a  = SRCA_PC;
            outs.alu_src_b  = SRCB_4;
            outs.result_src = RES_ALU;
            outs.ir_write   = mem_ready;
            outs.pc_write   = mem_ready;
         end
         DECODE: begin
            outs.alu_src_a  = SRCA_PC;
            outs.alu_src_b  = SRCB_4;
            outs.result_src = RES_ALU;
         end
         MEMADR: begin
            outs.alu_src_a = SRCA_RN;
            outs.alu_src_b = SRCB_IMM;
         end
         MEMRD: outs.adr_src = 1'b1;
         MEMWR: begin
            // strobe held through every wait cycle until the memory accepts it
            outs.adr_src   = 1'b1;
            outs.mem_write = cond_q;
         end
         MEMWB: begin
            outs.result_src = RES_RDATA;
            outs.reg_write  = cond_q;
            outs.pc_write   = cond_q & rd_pc;
         end
         EXECR: begin
            outs.alu_src_a = SRCA_RN;
            outs.alu_src_b = SRCB_REG;
            outs.alu_op    = 1'b1;
         end
         EXECI: begin
            outs.alu_src_a = SRCA_RN;
            outs.alu_src_b = SRCB_IMM;
            outs.alu_op    = 1'b1;
         end
         ALUWB: begin
            outs.result_src = RES_ALUOUT;
            outs.reg_write  = cond_q;
            outs.pc_write   = cond_q & rd_pc;
         end
         BRANCH: begin
            outs.alu_src_a  = SRCA_RN;
            outs.alu_src_b  = SRCB_IMM;
            outs.result_src = RES_ALU;
            outs.pc_write   = cond_q;
         end
         default: outs = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_seq_cu.sv
// rtl/multicycle_seq_cu.sv - main fetch/decode/execute/memory/writeback sequencer
module multicycle_seq_cu
   import cu_seq_pkg::*;
#(
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      op,
   input  logic [5:0]      funct,
   input  logic [3:0]      rd,
   input  logic            cond_ex,
   input  logic            mem_ready,
   output logic            ir_write,
   output logic            pc_write,
   output logic            adr_src,
   output logic [1:0]      alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      result_src,
   output logic            reg_write,
   output logic            mem_write,
   output logic            alu_op,
   output logic            illegal,
   output logic [ST_W-1:0] state_o
);

   state_t   state;
   state_t   state_nxt;
   logic     cond_q;
   seq_out_t dec;
   seq_out_t outs;
   logic     unused_funct;

   assign unused_funct = ^funct[4:1];

   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH:  state_nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_MEM:  state_nxt = MEMADR;
               OP_DP:   state_nxt = funct[5] ? EXECI : EXECR;
               OP_BR:   state_nxt = BRANCH;
               default: state_nxt = FETCH;
            endcase
         end
         MEMADR: state_nxt = funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_nxt = mem_ready ? MEMWB : MEMRD;
         MEMWR:  state_nxt = mem_ready ? FETCH : MEMWR;
         EXECR:  state_nxt = ALUWB;
         EXECI:  state_nxt = ALUWB;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FETCH;
         cond_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DECODE)
            cond_q <= cond_ex;
      end
   end

   seq_out_dec u_dec (
      .state     (state),
      .cond_q    (cond_q),
      .rd        (rd),
      .mem_ready (mem_ready),
      .outs      (dec)
   );

   // a reset arriving mid-instruction must not let a pending write leak out
   assign outs = reset ? '0 : dec;

   assign ir_write   = outs.ir_write;
   assign pc_write   = outs.pc_write;
   assign adr_src    = outs.adr_src;
   assign alu_src_a  = outs.alu_src_a;
   assign alu_src_b  = outs.alu_src_b;
   assign result_src = outs.result_src;
   assign reg_write  = outs.reg_write;
   assign mem_write  = outs.mem_write;
   assign alu_op     = outs.alu_op;
   assign illegal    = !reset && (state == DECODE) && (op == 2'b11);
   assign state_o    = ST_W'(state);

endmodule

// File: tb/tb_multicycle_seq_cu.sv
// tb/tb_multicycle_seq_cu.sv - directed and randomized checks of the multicycle sequencer
module tb_multicycle_seq_cu;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       cond_ex;
   logic       mem_ready;
   logic       ir_write, pc_write, adr_src, reg_write, mem_write, alu_op, illegal;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [3:0] state_o;

   always #5 clk = ~clk;

   multicycle_seq_cu #(.ST_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
      .cond_ex(cond_ex), .mem_ready(mem_ready),
      .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .reg_write(reg_write), .mem_write(mem_write), .alu_op(alu_op),
      .illegal(illegal), .state_o(state_o)
   );

   // one expected cycle: state, mem_ready to drive, and every control output
   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic       ir, pc, adr;
      logic [1:0] a, b, res;
      logic       rw, mw, aop, ill;
   } cyc_t;

   cyc_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic instr_cond;

   function automatic logic [16:0] pack_exp(cyc_t c);
      return {c.ir, c.pc, c.adr, c.a, c.b, c.res, c.rw, c.mw, c.aop, c.ill, c.st};
   endfunction

   function automatic logic [16:0] obs_vec();
      return {ir_write, pc_write, adr_src, alu_src_a, alu_src_b, result_src,
              reg_write, mem_write, alu_op, illegal, state_o};
   endfunction

   task automatic check(input string tag, input logic [16:0] exp_v);
      logic [16:0] obs;
      obs = obs_vec();
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h (ir pc adr a b res rw mw aop ill st)", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic [3:0] st, input logic mr, input logic ir, input logic pc,
                       input logic adr, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] res, input logic rw, input logic mw,
                       input logic aop, input logic ill);
      cyc_t c;
      c.st = st; c.mr = mr; c.ir = ir; c.pc = pc; c.adr = adr;
      c.a = a; c.b = b; c.res = res; c.rw = rw; c.mw = mw; c.aop = aop; c.ill = ill;
      q.push_back(c);
   endtask

   // Expected cycle list for one instruction, from the instruction class and wait counts
   task automatic build(input logic [1:0] o, input logic [5:0] f, input logic [3:0] d,
                        input logic c, input int fw, input int mw);
      logic wb_pc;
      wb_pc = c && (d == 4'd15);
      q.delete();
      for (int i = 0; i < fw; i++) push(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0);
      push(0, 1, 1, 1, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0);
      push(1, 1'($urandom_range(0, 1)), 0, 0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, o == 2'b11);
      case (o)
         2'b00: begin
            if (f[5]) push(7, 1'($urandom_range(0, 1)), 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0);
            else      push(6, 1'($urandom_range(0, 1)), 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
            push(8, 1'($urandom_range(0, 1)), 0, wb_pc, 0, 2'b00, 2'b00, 2'b00, c, 0, 0, 0);
         end
         2'b01: begin
            push(2, 1'($urandom_range(0, 1)), 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0);
            if (f[0]) begin
               for (int i = 0; i < mw; i++) push(3, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
               push(3, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
               push(5, 1'($urandom_range(0, 1)), 0, wb_pc, 0, 2'b00, 2'b00, 2'b01, c, 0, 0, 0);
            end else begin
               for (int i = 0; i <= mw; i++)
                  push(4, (i == mw), 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, c, 0, 0);
            end
         end
         2'b10: push(9, 1'($urandom_range(0, 1)), 0, c, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0);
         default: ;
      endcase
   endtask

   // cond_ex is only meaningful in DECODE; elsewhere it is scrambled
   task automatic exec(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         mem_ready = q[i].mr;
         cond_ex   = (q[i].st == 4'd1) ? instr_cond : 1'($urandom_range(0, 1));
         #1;
         check(tag, pack_exp(q[i]));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input string tag, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] d, input logic c, input int fw, input int mw);
      op = o; funct = f; rd = d; instr_cond = c;
      build(o, f, d, c, fw, mw);
      exec(tag, q.size());
   endtask

   initial begin
      reset = 1'b1; op = 2'b11; funct = '0; rd = '0; cond_ex = 1'b1; mem_ready = 1'b1;
      instr_cond = 1'b0;
      @(posedge clk); #1;
      check("reset_idle", 17'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // reset held two cycles while a store waits in MEMWR
      op = 2'b01; funct = 6'b000000; rd = 4'd2; instr_cond = 1'b1;
      build(2'b01, 6'b000000, 4'd2, 1'b1, 0, 5);
      exec("str_pre_reset", 5);
      reset = 1'b1; mem_ready = 1'b0;
      #1; check("reset_in_memwr_0", {13'd0, 4'd4});
      @(posedge clk); #1;
      check("reset_in_memwr_1", 17'd0);
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = 1'b0;
      #1; check("after_reset_fetch", {3'b000, 2'b01, 2'b10, 2'b10, 4'b0000, 4'd0});

      run_instr("add",        2'b00, 6'b001000, 4'd3,  1'b1, 0, 0);
      run_instr("ldr_wait2",  2'b01, 6'b011001, 4'd4,  1'b1, 0, 2);
      run_instr("str_cond0",  2'b01, 6'b011000, 4'd5,  1'b0, 0, 0);
      run_instr("b_cond1",    2'b10, 6'b000000, 4'd0,  1'b1, 0, 0);
      run_instr("b_cond0",    2'b10, 6'b000000, 4'd0,  1'b0, 0, 0);
      run_instr("undef",      2'b11, 6'b000000, 4'd0,  1'b1, 0, 0);
      run_instr("mov_pc",     2'b00, 6'b111010, 4'd15, 1'b1, 0, 0);
      run_instr("ldr_pc",     2'b01, 6'b011001, 4'd15, 1'b1, 1, 0);
      run_instr("ldr_pc_c0",  2'b01, 6'b011001, 4'd15, 1'b0, 0, 1);
      run_instr("str_wait3",  2'b01, 6'b011000, 4'd1,  1'b1, 2, 3);

      for (int n = 0; n < 150; n++) begin
         logic [1:0] ro;
         logic [5:0] rf;
         logic [3:0] rr;
         ro = 2'($urandom_range(0, 3));
         rf = 6'($urandom);
         rr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         run_instr("random", ro, rf, rr, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      mem_ready = 1'b0;
      #1; check("final_fetch", {3'b000, 2'b01, 2'b10, 2'b10, 4'b0000, 4'd0});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_seq_cu.md
Name: multicycle_seq_cu

Overview:
- Main sequencer for the multicycle build of the processor.
- Walks each instruction through fetch, decode, execute, memory and writeback states, and drives the per-cycle enables and mux selects of the shared datapath (one ALU, one memory port).
- Sits beside the combinational instruction decoder, which still supplies alu_control, imm_src and reg_src.
- The conditional-execution check stays external and arrives as cond_ex.

Parameters:
- ST_W, 4, width of the state_o debug output.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; forces FETCH
- op  in  2  instruction op field (00 DP, 01 MEM, 10 BRANCH, 11 undefined)
- funct  in  6  funct[5] = I (immediate), funct[0] = L (load) / S (flags)
- rd  in  4  destination register
- cond_ex  in  1  condition passed, from external condition logic
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1
- ir_write  out  1  latch instruction register
- pc_write  out  1  write PC
- adr_src  out  1  0 = PC, 1 = ALU result register as memory address
- alu_src_a  out  2  00 Rn, 01 PC, 10 PC+4
- alu_src_b  out  2  00 Rm/shifted, 01 extended imm, 10 constant 4
- result_src  out  2  00 ALU out register, 01 read data, 10 ALU direct
- reg_write  out  1  register-file write enable
- mem_write  out  1  memory write strobe
- alu_op  out  1  1 = use decoder alu_control, 0 = force ADD
- illegal  out  1  one-cycle pulse on op = 11
- state_o  out  ST_W  current state, for debug

Behaviour:
- Reset: state = FETCH; all outputs 0, including illegal. Reset in any state aborts the instruction; mem_write and reg_write are 0 in the cycle after reset.
- Outputs are Moore-style, decoded from state, except three gated terms:
  - pc_write also depends on mem_ready and rd.
  - reg_write and mem_write are ANDed with cond_ex (latched in DECODE).
- State actions and transitions:
  - FETCH: adr_src = 0, alu_src_a = 01, alu_src_b = 10, result_src = 10, alu_op = 0. ir_write = pc_write = mem_ready. Stay while mem_ready = 0; go to DECODE when 1.
  - DECODE: alu_src_a = 01, alu_src_b = 10, result_src = 10 (reads PC+8). Latch cond_ex into cond_q. Next state:
    - op 01 → MEMADR
    - op 00 → EXECR if funct[5] = 0, else EXECI
    - op 10 → BRANCH
    - op 11 → FETCH, with illegal = 1 for this cycle
  - MEMADR: alu_src_a = 00, alu_src_b = 01, alu_op = 0. Next is MEMRD if funct[0] = 1, else MEMWR.
  - MEMRD: adr_src = 1. Hold until mem_ready, then go to MEMWB.
  - MEMWR: adr_src = 1, mem_write = cond_q. Hold until mem_ready, then go to FETCH. mem_write stays asserted for every wait cycle.
  - MEMWB: result_src = 01, reg_write = cond_q. If rd = 15 and cond_q, also pc_write = 1. Next is FETCH.
  - EXECR: alu_src_a = 00, alu_src_b = 00, alu_op = 1. Next is ALUWB.
  - EXECI: alu_src_a = 00, alu_src_b = 01, alu_op = 1. Next is ALUWB.
  - ALUWB: result_src = 00, reg_write = cond_q. If rd = 15, pc_write = cond_q. Next is FETCH.
  - BRANCH: alu_src_a = 00 (PC+8 path via decoder reg_src), alu_src_b = 01, result_src = 10, alu_op = 0, pc_write = cond_q. Next is FETCH.
- Latency in cycles, assuming mem_ready is always 1: DP = 4, LDR = 5, STR = 4, B = 3, undefined = 2.
- Boundaries:
  - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
  - A cond_q = 0 instruction still walks the full sequence but commits nothing (no reg_write, mem_write or pc_write beyond the fetch).
  - No output has an X path; unused states decode to FETCH with all outputs 0.

Decomposition:
- Package cu_seq_pkg holds:
  - state_t enum (4 bits): FETCH = 0, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXECR, EXECI, ALUWB, BRANCH.
  - Select encodings: SRCA_RN, SRCA_PC, SRCA_PC4, SRCB_REG, SRCB_IMM, SRCB_4, RES_ALUOUT, RES_RDATA, RES_ALU.
  - OP_DP, OP_MEM, OP_BR.
- One sub-module, seq_out_dec: pure combinational decode of state_t plus cond_q, rd and mem_ready into the output vector. The top level keeps the state register, cond_q and the next-state logic.

Test Plan:
- Reset held 2 cycles in MEMWR with mem_ready = 0 → next cycle state_o = 0 and mem_write = 0.
- ADD (op 00, funct 001000, rd = 3, cond_ex = 1, mem_ready = 1) → states 0, 1, 6, 8. reg_write = 1 only in ALUWB; pc_write = 1 only in FETCH.
- LDR (op 01, funct 011001) with mem_ready low for 2 cycles in MEMRD → MEMRD lasts 3 cycles, then MEMWB has result_src = 01 and reg_write = 1. Total 7 cycles.
- STR with cond_ex = 0 → walks MEMADR then MEMWR; mem_write stays 0; returns to FETCH.
- B with cond_ex = 1 → pc_write = 1 in BRANCH with alu_src_b = 01, and 3 cycles total. Repeat with cond_ex = 0 → pc_write = 0 in BRANCH.
- op = 11 → illegal = 1 for exactly 1 cycle in DECODE, then FETCH. MOV to rd = 15 (DP, cond 1) → pc_write = 1 in ALUWB.
